// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures the period of a slow square wave in clk cycles,
// classifies its divide ratio, tracks lock and flags loss of signal.
module clk_ratio_meter #(
    parameter int CNT_W      = 8,
    parameter int MAX_PERIOD = 255,
    parameter int LOCK_N     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [2:0]       ratio,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_N);
    localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_rise;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [2:0]       r_ratio;
    logic             r_meas_valid;
    logic             r_timeout;
    logic             r_locked;
    logic             r_have_prev;
    logic [MW-1:0]    r_match;

    logic             w_cnt_at_max;
    logic             w_same;
    logic             w_start;
    logic             w_meas;
    logic             w_tmo;
    logic             w_abort;
    logic             w_cnt_inc;

    function automatic logic [2:0] f_code(input logic [CNT_W-1:0] v);
        logic [31:0] w_v;
        logic [2:0]  w_c;
        w_v = 32'(v);
        case (w_v)
            32'd2:   w_c = 3'd1;
            32'd4:   w_c = 3'd2;
            32'd8:   w_c = 3'd3;
            32'd16:  w_c = 3'd4;
            default: w_c = 3'd0;
        endcase
        return w_c;
    endfunction

    // Two flops resync the async input; the third gives the edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise       = r_s2 & ~r_s3;
    assign w_cnt_at_max = (r_cnt == CNT_MAX);
    assign w_same       = (r_cnt == r_period);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (en && w_rise) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!en || (!w_rise && w_cnt_at_max)) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // A rise at the last legal count still measures; timeout needs no rise.
    always_comb begin
        w_start   = 1'b0;
        w_meas    = 1'b0;
        w_tmo     = 1'b0;
        w_abort   = 1'b0;
        w_cnt_inc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_start = en & w_rise;
            end
            S_MEASURE: begin
                if (!en) begin
                    w_abort = 1'b1;
                end else if (w_rise) begin
                    w_meas = 1'b1;
                end else if (w_cnt_at_max) begin
                    w_tmo = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_period     <= '0;
            r_ratio      <= 3'd0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= w_meas;
            r_timeout    <= w_tmo;
            if (w_start || w_meas) begin
                r_cnt <= CNT_ONE;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= '0;
            end
            if (w_meas) begin
                r_period <= r_cnt;
                r_ratio  <= f_code(r_cnt);
            end
        end
    end

    // First measurement after idle only seeds the reference period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_have_prev <= 1'b0;
            r_match     <= '0;
            r_locked    <= 1'b0;
        end else if (w_abort || w_tmo) begin
            r_have_prev <= 1'b0;
            r_match     <= '0;
            r_locked    <= 1'b0;
        end else if (w_meas) begin
            r_have_prev <= 1'b1;
            if (r_have_prev) begin
                if (w_same) begin
                    if (r_match != MATCH_MAX) begin
                        r_match <= r_match + MATCH_ONE;
                    end
                    if (r_match >= MATCH_MAX - MATCH_ONE) begin
                        r_locked <= 1'b1;
                    end
                end else begin
                    r_match  <= '0;
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign period     = r_period;
    assign ratio      = r_ratio;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: directed and randomized square waves checked against
// an edge-distance reference model of the ratio meter.
module tb_clk_ratio_meter;

    localparam int CNT_W = 8;
    localparam int MAXP  = 255;
    localparam int LOCKN = 3;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             en     = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [2:0]       ratio;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int checks    = 0;
    int failures  = 0;
    int mv_count  = 0;
    int to_count  = 0;

    always #5 clk = ~clk;

    clk_ratio_meter #(
        .CNT_W     (CNT_W),
        .MAX_PERIOD(MAXP),
        .LOCK_N    (LOCKN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .ratio     (ratio),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Square wave source; new high/low lengths take effect on a period boundary.
    bit gen_on = 1'b0;
    int hi = 1, lo = 1, hi_n = 1, lo_n = 1, ph = 0;

    always @(negedge clk) begin
        if (!gen_on) begin
            sig_in = 1'b0;
            ph = 0;
            hi = hi_n;
            lo = lo_n;
        end else begin
            if (ph == 0) begin
                hi = hi_n;
                lo = lo_n;
            end
            sig_in = (ph < hi);
            ph = (ph + 1 >= hi + lo) ? 0 : ph + 1;
        end
    end

    task automatic set_wave(input int h, input int l);
        hi_n = h;
        lo_n = l;
    endtask

    // Reference model: periods are distances between qualified rising edges.
    bit m_h1, m_h2, m_h3, m_rise, m_arm, m_prev_ok;
    int m_cyc, m_tlast, m_match, m_p;
    int e_period, e_ratio, e_mv, e_to, e_locked;

    function automatic int code_of(input int p);
        case (p)
            2:       return 1;
            4:       return 2;
            8:       return 3;
            16:      return 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_h1 = 0; m_h2 = 0; m_h3 = 0;
            m_arm = 0; m_prev_ok = 0;
            m_cyc = 0; m_tlast = 0; m_match = 0;
            e_period = 0; e_ratio = 0; e_mv = 0; e_to = 0; e_locked = 0;
        end else begin
            m_cyc++;
            m_rise = m_h2 && !m_h3;
            e_mv = 0;
            e_to = 0;
            if (!m_arm) begin
                if (en && m_rise) begin
                    m_arm = 1;
                    m_tlast = m_cyc;
                end
            end else if (!en) begin
                m_arm = 0; m_prev_ok = 0; m_match = 0; e_locked = 0;
            end else if (m_rise) begin
                m_p = m_cyc - m_tlast;
                m_tlast = m_cyc;
                e_mv = 1;
                if (m_prev_ok && m_p == e_period) begin
                    if (m_match < LOCKN) m_match++;
                    if (m_match == LOCKN) e_locked = 1;
                end else if (m_prev_ok) begin
                    m_match = 0;
                    e_locked = 0;
                end
                m_prev_ok = 1;
                e_period = m_p;
                e_ratio = code_of(m_p);
            end else if (m_cyc - m_tlast == MAXP) begin
                e_to = 1;
                m_arm = 0; m_prev_ok = 0; m_match = 0; e_locked = 0;
            end
            m_h3 = m_h2;
            m_h2 = m_h1;
            m_h1 = sig_in;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("period", int'(period), e_period);
            chk("ratio", int'(ratio), e_ratio);
            chk("meas_valid", int'(meas_valid), e_mv);
            chk("timeout", int'(timeout), e_to);
            chk("locked", int'(locked), e_locked);
            chk("strobe_excl", int'(meas_valid & timeout), 0);
            if (meas_valid) mv_count++;
            if (timeout) to_count++;
        end
    end

    task automatic wait_mv(input int n, input string name);
        int target;
        int budget;
        target = mv_count + n;
        budget = 0;
        while (mv_count < target && budget < n * 600 + 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (mv_count < target) chk(name, mv_count, target);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_period"}, int'(period), 0);
        chk({name, "_ratio"}, int'(ratio), 0);
        chk({name, "_mv"}, int'(meas_valid), 0);
        chk({name, "_locked"}, int'(locked), 0);
        chk({name, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, t0, m0, r;

        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // divide by 2
        en = 1'b1;
        set_wave(1, 1);
        gen_on = 1'b1;
        wait_mv(1, "d2_first");
        chk("d2_period", int'(period), 2);
        chk("d2_ratio", int'(ratio), 1);
        wait_mv(2, "d2_third");
        chk("d2_unlocked3", int'(locked), 0);
        wait_mv(1, "d2_fourth");
        chk("d2_locked4", int'(locked), 1);

        // divide by 16
        set_wave(8, 8);
        wait_mv(6, "d16");
        chk("d16_period", int'(period), 16);
        chk("d16_ratio", int'(ratio), 4);
        chk("d16_locked", int'(locked), 1);

        // lock on /8 then move to /4
        set_wave(4, 4);
        wait_mv(6, "d8");
        chk("d8_locked", int'(locked), 1);
        chk("d8_period", int'(period), 8);
        set_wave(2, 2);
        n = 0;
        do begin
            wait_mv(1, "d4_switch");
            n++;
        end while (period != 4 && n < 4);
        chk("d4_period", int'(period), 4);
        chk("d4_ratio", int'(ratio), 2);
        chk("d4_lock_drop", int'(locked), 0);
        wait_mv(2, "d4_relock2");
        chk("d4_not_yet", int'(locked), 0);
        wait_mv(1, "d4_relock3");
        chk("d4_relocked", int'(locked), 1);

        // period 6 is unclassified but still locks
        set_wave(3, 3);
        wait_mv(6, "p6");
        chk("p6_period", int'(period), 6);
        chk("p6_ratio", int'(ratio), 0);
        chk("p6_locked", int'(locked), 1);

        // loss of signal while locked on /4
        set_wave(2, 2);
        wait_mv(6, "los_pre");
        chk("los_pre_locked", int'(locked), 1);
        gen_on = 1'b0;
        t0 = to_count;
        n = 0;
        while (to_count == t0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("los_timeout", int'(timeout), 1);
        chk("los_locked", int'(locked), 0);
        chk("los_period_hold", int'(period), 4);
        repeat (50) @(negedge clk);
        #1;
        chk("los_single", to_count, t0 + 1);
        gen_on = 1'b1;
        wait_mv(1, "los_resume");
        chk("los_resume_period", int'(period), 4);
        chk("los_resume_unlocked", int'(locked), 0);

        // en drop while locked
        wait_mv(4, "en_pre");
        chk("en_pre_locked", int'(locked), 1);
        en = 1'b0;
        @(negedge clk);
        #1;
        en = 1'b1;
        chk("en_drop_unlocked", int'(locked), 0);
        wait_mv(2, "en_after");
        chk("en_after_unlocked", int'(locked), 0);

        // a rise exactly at the last legal count is a valid measurement
        set_wave(1, 254);
        t0 = to_count;
        wait_mv(3, "p255");
        chk("p255_period", int'(period), 255);
        chk("p255_ratio", int'(ratio), 0);
        chk("p255_no_timeout", to_count, t0);

        // one cycle too long: only timeouts
        set_wave(1, 255);
        repeat (300) @(negedge clk);
        #1;
        m0 = mv_count;
        t0 = to_count;
        repeat (1030) @(negedge clk);
        #1;
        chk("p256_no_meas", mv_count, m0);
        chk("p256_timeouts", to_count - t0, 4);

        // async reset mid-measurement
        set_wave(8, 8);
        wait_mv(2, "rst_pre");
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        #1;
        rst = 1'b1;

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                gen_on = 1'b0;
                repeat ($urandom_range(200, 300)) @(negedge clk);
                #1;
                gen_on = 1'b1;
            end else if (r == 1) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
                en = 1'b1;
            end else if (r == 2) begin
                #2;
                rst = 1'b0;
                @(negedge clk);
                #1;
                rst = 1'b1;
            end else begin
                set_wave($urandom_range(1, 10), $urandom_range(1, 10));
            end
            repeat ($urandom_range(20, 150)) @(negedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
